// File: rtl/unified_mem_responder.sv
// Word-addressed unified memory responder: accepts a request in IDLE, ready pulses WAIT_STATES+1 cycles later; req ignored while busy.
// Optional macro MEM_ALIGN_CHECK_EN flags misaligned accesses on err and suppresses their commit.
module unified_mem_responder #(
   parameter int    DEPTH_WORDS = 64,
   parameter int    WAIT_STATES = 2,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        ready,
   output logic        busy,
   output logic        err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [3:0]      r_cnt;
   logic [AW-1:0]   r_idx;
   logic            r_we;
   logic [31:0]     r_wdata;
   logic [31:0]     r_rdata;
   logic [31:0]     r_mem [DEPTH_WORDS];

   logic            w_accept;
   logic            w_commit;
   logic            w_fault;
   logic            w_live_fault;
   logic [AW-1:0]   w_c_idx;
   logic            w_c_we;
   logic [31:0]     w_c_wdata;
   logic            w_c_fault;
   logic            w_unused_adr;

   assign w_accept     = (r_state == S_IDLE) && req;
   assign w_unused_adr = ^{Adr[31:AW+2], Adr[1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req) w_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
         S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_we    <= 1'b0;
         r_wdata <= 32'd0;
      end else if (w_accept) begin
         r_cnt   <= 4'(WAIT_STATES);
         r_idx   <= Adr[AW+1:2];
         r_we    <= we;
         r_wdata <= WriteData;
      end else if (r_state == S_WAIT) begin
         r_cnt   <= r_cnt - 4'd1;
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic r_fault;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_fault <= 1'b0;
      else if (w_accept) r_fault <= (Adr[1:0] != 2'b00);
   end

   assign w_fault      = r_fault;
   assign w_live_fault = (Adr[1:0] != 2'b00);
   assign err          = (r_state == S_RESP) && r_fault;
`else
   assign w_fault      = 1'b0;
   assign w_live_fault = 1'b0;
   assign err          = 1'b0;
`endif

   // With zero wait states the commit edge is also the accept edge, so take the live inputs then.
   assign w_c_idx   = (r_state == S_IDLE) ? Adr[AW+1:2] : r_idx;
   assign w_c_we    = (r_state == S_IDLE) ? we          : r_we;
   assign w_c_wdata = (r_state == S_IDLE) ? WriteData   : r_wdata;
   assign w_c_fault = (r_state == S_IDLE) ? w_live_fault : w_fault;
   assign w_commit  = (w_next == S_RESP) && (r_state != S_RESP) && !reset;

   always_ff @(posedge clk) begin
      if (w_commit && w_c_we && !w_c_fault) r_mem[w_c_idx] <= w_c_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                  r_rdata <= 32'd0;
      else if (w_commit && !w_c_we && !w_c_fault) r_rdata <= r_mem[w_c_idx];
   end

   assign ReadData = r_rdata;
   assign ready    = (r_state == S_RESP);
   assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_unified_mem_responder.sv
// Scoreboard bench for unified_mem_responder (DEPTH_WORDS=64, WAIT_STATES=2).
module tb_unified_mem_responder;

   localparam int WS = 2;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] Adr = 32'd0;
   logic [31:0] WriteData = 32'd0;
   logic [31:0] ReadData;
   logic        ready;
   logic        busy;
   logic        err;

   exp_t        q[$];
   exp_t        mon_e;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] mem_model [64];
   logic [31:0] model_rd = 32'd0;
   logic [31:0] prev_word;

   unified_mem_responder #(
      .DEPTH_WORDS(64),
      .WAIT_STATES(WS),
      .INIT_FILE("")
   ) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .we(we),
      .Adr(Adr),
      .WriteData(WriteData),
      .ReadData(ReadData),
      .ready(ready),
      .busy(busy),
      .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Expected response for a request presented now and accepted on the coming edge.
   // ready must be visible in the cycle where cyc == accept edge count + WS.
   task automatic push_exp(input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_t       e;
      logic       f;
      logic [5:0] idx;
      idx = a[7:2];
`ifdef MEM_ALIGN_CHECK_EN
      f = (a[1:0] != 2'b00);
`else
      f = 1'b0;
`endif
      if (!f) begin
         if (w) mem_model[idx] = d;
         else   model_rd = mem_model[idx];
      end
      e.data = model_rd;
      e.err  = f;
      e.cyc  = cyc + 1 + WS;
      q.push_back(e);
   endtask

   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req = 1'b1; we = w; Adr = a; WriteData = d;
      push_exp(w, a, d);
      @(negedge clk);
      req = 1'b0; we = ~w; Adr = ~a; WriteData = ~d;
   endtask

   task automatic wait_done();
      int k;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         #1;
         if (q.size() == 0) break;
      end
      if (k == 40) begin
         n_tests++;
         n_fail++;
         $display("FAIL response_timeout: got no ready within 40 cycles, required ready for %0d pending", q.size());
         q.delete();
      end
   endtask

   always @(negedge clk) begin
      if (!reset && ready) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ready: got ready=1 at cycle %0d, required no pending response", cyc);
         end else begin
            mon_e = q.pop_front();
            check32("resp_rdata", ReadData, mon_e.data);
            check32("resp_err", {31'd0, err}, {31'd0, mon_e.err});
            check32("resp_cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      check32("rst_ready", {31'd0, ready}, 32'd0);
      check32("rst_busy", {31'd0, busy}, 32'd0);
      check32("rst_err", {31'd0, err}, 32'd0);
      check32("rst_rdata", ReadData, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // write then read back
      issue(1'b1, 32'h10, 32'h12345678);
      wait_done();
      issue(1'b0, 32'h10, 32'h0);
      wait_done();

      // address wrap modulo 256 bytes
      issue(1'b1, 32'h100, 32'hA5A5A5A5);
      wait_done();
      issue(1'b0, 32'h000, 32'h0);
      wait_done();

      // asynchronous reset in the middle of a cycle during WAIT
      issue(1'b0, 32'h10, 32'h0);
      @(posedge clk);
      #2;
      check32("pre_rst_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check32("async_rst_ready", {31'd0, ready}, 32'd0);
      check32("async_rst_busy", {31'd0, busy}, 32'd0);
      check32("async_rst_err", {31'd0, err}, 32'd0);
      check32("async_rst_rdata", ReadData, 32'd0);
      q.delete();
      model_rd = 32'd0;
      @(negedge clk);
      reset = 1'b0;

      // req held high for three back-to-back transactions with junk inputs between accepts
      for (int k = 0; k <= 12; k++) begin
         @(negedge clk);
         if (k >= 1) begin
            check32("b2b_busy", {31'd0, busy}, {31'd0, ((k - 1) % 4) != 3});
            check32("b2b_ready", {31'd0, ready}, {31'd0, ((k - 1) % 4) == 2});
         end
         if (k == 12) begin
            req = 1'b0;
         end else if (k % 4 == 0) begin
            req = 1'b1;
            case (k / 4)
               0:       begin we = 1'b1; Adr = 32'h40; WriteData = 32'hCAFEF00D; end
               1:       begin we = 1'b1; Adr = 32'h44; WriteData = 32'h600DBEEF; end
               default: begin we = 1'b0; Adr = 32'h40; WriteData = 32'h0; end
            endcase
            push_exp(we, Adr, WriteData);
         end else begin
            we = 1'b1; Adr = 32'h44; WriteData = 32'hDEADDEAD;
         end
      end
      wait_done();
      issue(1'b0, 32'h44, 32'h0);
      wait_done();

      // reset during WAIT discards an uncommitted write
      issue(1'b1, 32'h20, 32'h11111111);
      wait_done();
      prev_word = mem_model[8];
      issue(1'b1, 32'h20, 32'h0BADF00D);
      #1;
      reset = 1'b1;
      q.delete();
      mem_model[8] = prev_word;
      model_rd = 32'd0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      issue(1'b0, 32'h20, 32'h0);
      wait_done();

      // misaligned read
      issue(1'b0, 32'h13, 32'h0);
      wait_done();

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
